// File: rtl/shiftregister_sequencer5.sv
// Sequences preset, SHIFT_COUNT shift pulses and LSB-first capture for a 5-bit shift register.
// Define SHIFTREG_SEQ_ROTATE_EN to feed sr_q[0] back as the serial input (rotate mode).
module shiftregister_sequencer5 #(
    parameter int WIDTH       = 5,
    parameter int SHIFT_COUNT = 5
) (
    input  logic             clockpulse,
    input  logic             clear_,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fill,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_clockpulse,
    output logic             sr_clear,
    output logic             sr_preset_enable,
    output logic [WIDTH-1:0] sr_preset,
    output logic             sr_serial_input,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(SHIFT_COUNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             clk_q, clk_d;
    logic             clr_q, clr_d;
    logic             pe_q, pe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             unused_bits;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        result_d = result_q;
        if (abort) begin
            state_d  = S_ABORT;
            result_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_LOAD_HI;
                        preset_d = data_in;
                        result_d = '0;
                        cnt_d    = '0;
                    end
                end
                S_LOAD_HI: state_d = S_LOAD_LO;
                S_LOAD_LO: begin
                    state_d  = S_SHIFT_HI;
                    result_d = {sr_q[0], result_q[WIDTH-1:1]};
                end
                S_SHIFT_HI: begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = cnt_q + 1'b1;
                end
                S_SHIFT_LO: begin
                    if (cnt_q == CW'(SHIFT_COUNT)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_SHIFT_HI;
                        result_d = {sr_q[0], result_q[WIDTH-1:1]};
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ABORT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        clk_d  = (state_d == S_LOAD_HI) || (state_d == S_SHIFT_HI);
        pe_d   = (state_d == S_LOAD_HI);
        clr_d  = (state_d == S_ABORT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            preset_q <= '0;
            result_q <= '0;
            clk_q    <= 1'b0;
            clr_q    <= 1'b1;
            pe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
            result_q <= result_d;
            clk_q    <= clk_d;
            clr_q    <= clr_d;
            pe_q     <= pe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SHIFTREG_SEQ_ROTATE_EN
    assign sr_serial_input = sr_q[0];
    assign unused_bits     = ^{sr_q[WIDTH-1:1], fill};
`else
    assign sr_serial_input = fill;
    assign unused_bits     = ^sr_q[WIDTH-1:1];
`endif

    assign sr_clockpulse    = clk_q;
    assign sr_clear         = clr_q;
    assign sr_preset_enable = pe_q;
    assign sr_preset        = preset_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;

endmodule

// File: doc/shiftregister_sequencer5.md
Name: shiftregister_sequencer5

Overview:
Controller that sequences the 5-bit right shift register (clockpulse/clear/serial_input/preset_enable/preset interface) from a free-running system clock. On a start request it:
- presets the register with a word;
- generates exactly SHIFT_COUNT shift pulses;
- captures the serial output (sr_q[0]), LSB first;
- reports completion.

It replaces hand-driven clock/preset sequences and sits between user control logic and the shift-register instance.

Parameters:
WIDTH, 5, register width (data_in, sr_preset, sr_q, result)
SHIFT_COUNT, 5, shift pulses per operation; legal range 1..31; result fully valid when SHIFT_COUNT == WIDTH

Ports:
clockpulse  input  1  system clock; all state changes on rising edge
clear_  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
abort  input  1  cancel current operation / clear register
data_in  input  WIDTH  word to preset; latched when start is accepted
fill  input  1  serial fill bit shifted into the MSB
sr_q  input  WIDTH  signal_q from the shift register
sr_clockpulse  output  1  clock to the shift register (registered)
sr_clear  output  1  active-high clear to the shift register (registered)
sr_preset_enable  output  1  preset enable to the shift register (registered)
sr_preset  output  WIDTH  preset word (holds latched data_in)
sr_serial_input  output  1  serial input to the shift register
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal completion
result  output  WIDTH  captured serial output word

Behaviour:
- Reset (clear_ low, asynchronous):
  - state = IDLE; sr_clear = 1.
  - sr_clockpulse, sr_preset_enable, busy and done = 0; sr_preset and result = 0; shift counter = 0.
  - sr_clear drops to 0 at the first clockpulse edge after clear_ rises.
- States: IDLE, LOAD_HI, LOAD_LO, SHIFT_HI, SHIFT_LO, DONE, ABORT. All outputs are registered except sr_serial_input.
- IDLE: start=1 at edge E0 → latch data_in into sr_preset, clear result, counter = 0, go to LOAD_HI.
- LOAD_HI (cycle after E0): sr_preset_enable = 1, sr_clockpulse = 1.
- LOAD_LO: sr_clockpulse = 0, sr_preset_enable = 0. Preset-enable falls together with the clock, never before it.
- SHIFT_HI:
  - sr_clockpulse = 1.
  - At the edge entering SHIFT_HI, capture the pre-shift sr_q[0]: result <= {sr_q[0], result[WIDTH-1:1]}.
  - Shift pulse k (k = 0..SHIFT_COUNT-1) is entered at edge E(2+2k).
- SHIFT_LO: sr_clockpulse = 0, counter++. If counter reaches SHIFT_COUNT go to DONE, else go to SHIFT_HI.
- DONE: done = 1 for one cycle, entered at edge E(2*SHIFT_COUNT+2); busy still 1. Next state IDLE.
- Latency: 12 cycles from the start-accept edge to the done cycle with default parameters.
- sr_serial_input = fill (combinational); valid whenever sr_clockpulse rises.
- Capture ordering: first captured bit = data_in[0]. With SHIFT_COUNT == WIDTH, result == data_in at done.
- start while busy: ignored; no queueing.
- abort=1 in any state including IDLE:
  - Next state ABORT: sr_clear = 1, sr_clockpulse = 0, sr_preset_enable = 0, result = 0 for one cycle.
  - Then IDLE. done is never asserted for an aborted operation.
  - abort and start in the same IDLE cycle: abort wins, start is dropped.
- Reset mid-operation: immediate return to the reset values above; no done.

Optional Feature:
Macro SHIFTREG_SEQ_ROTATE_EN.
- Defined: sr_serial_input = sr_q[0], so the register rotates. After WIDTH pulses sr_q equals the preset word; fill is ignored.
- Undefined: sr_serial_input = fill.
- Capture, timing and handshake are identical in both builds.

Test Plan:
1. clear_ low 3 cycles → sr_clear=1, busy=0, done=0, result=00000. First edge after release → sr_clear=0.
2. start, data_in=5'b11000, fill=0 →
   - sr_preset_enable high for exactly one sr_clockpulse high phase;
   - then 5 clock pulses, each 1 cycle high / 1 cycle low;
   - done at cycle 12; result=5'b11000; sr_q=5'b00000.
3. start, data_in=5'b00101, fill=1 → done at cycle 12; result=5'b00101; final sr_q=5'b11111.
4. abort during shift pulse 3 → sr_clear=1 for one cycle, busy low next cycle, no done pulse, result=00000, sr_q=00000.
5. start held high through an operation → exactly one done; new operation accepted only after return to IDLE. start+abort together in IDLE → ABORT, no load.
6. SHIFTREG_SEQ_ROTATE_EN defined, data_in=5'b10110, fill=0 → done at cycle 12; final sr_q=5'b10110; result=5'b10110.
